crt_row_fetch: RTL and testbench



---
 rtl/crt_pkg.sv | 38 +++
 rtl/crt_row_ram.sv | 44 ++++
 rtl/crt_row_fetch.sv | 237 +++++++++++++++++++++++
 tb/tb_crt_row_fetch.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crt_pkg.sv
// -----------------------------------------------------------------------------
// crt_pkg
// Shared types and decode helpers for the CRT row-fetch engine.
//   crt_state_e      : fetch-engine state encoding
//   BURST_LEN_LUT    : cfg_burst_cnt -> characters per DMA burst
//   BURST_SPACE_LUT  : cfg_burst_space -> char clocks idle between bursts
//   is_stop_code     : byte ends the current row
//   is_eos_code      : byte ends the screen (halts until next frame)
//   is_field_attr    : byte is a field-attribute character
// -----------------------------------------------------------------------------
package crt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SPACE,
    ST_DONE,
    ST_HALT
  } crt_state_e;

  // Element [n] is the value selected by configuration code n.
  localparam logic [3:0][3:0] BURST_LEN_LUT   = {4'd8, 4'd4, 4'd2, 4'd1};
  localparam logic [7:0][5:0] BURST_SPACE_LUT = {6'd55, 6'd47, 6'd39, 6'd31,
                                                 6'd23, 6'd15, 6'd7,  6'd0};

  function automatic logic is_stop_code(input logic [7:0] b);
    return (b[7:4] == 4'hF) && b[0];
  endfunction

  function automatic logic is_eos_code(input logic [7:0] b);
    return is_stop_code(b) && b[1];
  endfunction

  function automatic logic is_field_attr(input logic [7:0] b);
    return b[7:6] == 2'b10;
  endfunction

endpackage

// File: rtl/crt_row_ram.sv
// -----------------------------------------------------------------------------
// crt_row_ram
// Dual-bank buffer: one write port, one registered read port. The writer and
// reader address opposite banks so a row can be fetched while the previous one
// is displayed.
//   i_wr_en/i_wr_bank/i_wr_addr/i_wr_data : write port
//   i_rd_bank/i_rd_addr                   : read address, o_rd_data one cycle later
// -----------------------------------------------------------------------------
module crt_row_ram #(
  parameter int DEPTH = 80,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_wr_en,
  input  logic                     i_wr_bank,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_bank,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [2][DEPTH];

  // NOTE: the storage array has no reset so it maps onto plain RAM; only the
  // read-data register is reset to give a defined output after reset.
  always_ff @(posedge clk) begin
    if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_rd_data <= '0;
    end else if (int'(i_rd_addr) < DEPTH) begin
      o_rd_data <= r_mem[i_rd_bank][i_rd_addr];
    end else begin
      o_rd_data <= '0;
    end
  end

endmodule

// File: rtl/crt_row_fetch.sv
// -----------------------------------------------------------------------------
// crt_row_fetch
// DMA row-fetch engine. Fetches one row of characters (plus inline field
// attributes) per row_start into the write bank while the display bank is
// read by the pixel pipeline.
//   clk, reset_n (sync, active-low)
//   char_en, frame_start, row_start        : timing strobes
//   cfg_*                                  : geometry / burst configuration
//   drq, dack, ichar                       : DMA handshake and data
//   rd_col/rd_char, rd_fidx/rd_fdata       : display-bank reads, 1-cycle latency
//   row_done, st_underrun/overrun/eos      : status (st_* sticky, status_clr)
// -----------------------------------------------------------------------------
module crt_row_fetch
  import crt_pkg::*;
#(
  parameter int COLS       = 80,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          char_en,
  input  logic                          frame_start,
  input  logic                          row_start,
  input  logic [$clog2(COLS)-1:0]       cfg_cols,
  input  logic                          cfg_fillattr,
  input  logic [1:0]                    cfg_burst_cnt,
  input  logic [2:0]                    cfg_burst_space,
  input  logic                          cfg_dma_en,
  output logic                          drq,
  input  logic                          dack,
  input  logic [7:0]                    ichar,
  input  logic [$clog2(COLS)-1:0]       rd_col,
  output logic [7:0]                    rd_char,
  input  logic [$clog2(FIFO_DEPTH)-1:0] rd_fidx,
  output logic [6:0]                    rd_fdata,
  output logic                          row_done,
  output logic                          st_underrun,
  output logic                          st_overrun,
  output logic                          st_eos,
  input  logic                          status_clr
);

  localparam int CW = $clog2(COLS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] FIFO_FULL = (FW+1)'(FIFO_DEPTH);

  crt_state_e  r_state, w_state_nxt;
  logic        r_wbank, w_wbank_nxt;
  logic [CW:0] r_col, w_col_nxt;
  logic [FW:0] r_fifo_wp, w_fifo_wp_nxt;
  logic [3:0]  r_burst, w_burst_nxt;
  logic [5:0]  r_space, w_space_nxt;
  logic        r_attr_pend, w_attr_pend_nxt;
  logic        r_dack_q;
  logic        r_underrun, r_overrun, r_eos;

  logic        w_xfer, w_row_we, w_fifo_we;
  logic        w_row_end, w_halt_eos, w_burst_full;
  logic        w_set_underrun, w_set_overrun, w_set_eos;
  logic [CW:0] w_col_end;
  logic [3:0]  w_burst_len;
  logic [5:0]  w_space_len;

  // A transfer is a dack rising edge seen while requesting; ichar is taken
  // in that same cycle.
  assign w_xfer      = (r_state == ST_REQ) && dack && !r_dack_q;
  assign w_col_end   = {1'b0, cfg_cols} + 1'b1;
  assign w_burst_len = BURST_LEN_LUT[cfg_burst_cnt];
  assign w_space_len = BURST_SPACE_LUT[cfg_burst_space];

  always_comb begin
    // NOTE: every signal written here is defaulted first so no path leaves a
    // value unassigned, which would infer a latch.
    w_state_nxt     = r_state;
    w_wbank_nxt     = r_wbank;
    w_col_nxt       = r_col;
    w_fifo_wp_nxt   = r_fifo_wp;
    w_burst_nxt     = r_burst;
    w_space_nxt     = r_space;
    w_attr_pend_nxt = r_attr_pend;
    w_row_we        = 1'b0;
    w_fifo_we       = 1'b0;
    w_row_end       = 1'b0;
    w_halt_eos      = 1'b0;
    w_burst_full    = 1'b0;
    w_set_underrun  = 1'b0;
    w_set_overrun   = 1'b0;
    w_set_eos       = 1'b0;

    // Byte handling: the byte after a transparent attribute goes to the FIFO.
    if (w_xfer) begin
      if (r_attr_pend) begin
        w_attr_pend_nxt = 1'b0;
        if (r_fifo_wp != FIFO_FULL) begin
          w_fifo_we     = 1'b1;
          w_fifo_wp_nxt = r_fifo_wp + 1'b1;
        end else begin
          w_set_overrun = 1'b1;
        end
        // The last column may have been reached while this byte was pending.
        w_row_end = (r_col == w_col_end);
      end else begin
        w_row_we        = 1'b1;
        w_col_nxt       = r_col + 1'b1;
        w_attr_pend_nxt = is_field_attr(ichar) && !cfg_fillattr;
        if (is_stop_code(ichar)) begin
          w_attr_pend_nxt = 1'b0;
          w_row_end       = 1'b1;
          w_halt_eos      = is_eos_code(ichar);
          w_set_eos       = is_eos_code(ichar);
        end else begin
          w_row_end = (w_col_nxt == w_col_end) && !w_attr_pend_nxt;
        end
      end
      if (r_burst + 1'b1 == w_burst_len) begin
        w_burst_full = 1'b1;
        w_burst_nxt  = '0;
      end else begin
        w_burst_nxt = r_burst + 1'b1;
      end
    end

    case (r_state)
      ST_REQ: begin
        if (!cfg_dma_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_halt_eos) begin
          w_state_nxt = ST_HALT;
        end else if (w_row_end) begin
          w_state_nxt = ST_DONE;
        end else if (w_burst_full && (w_space_len != 6'd0)) begin
          w_state_nxt = ST_SPACE;
          w_space_nxt = '0;
        end
      end
      ST_SPACE: begin
        if (!cfg_dma_en) begin
          w_state_nxt = ST_IDLE;
        end else if (char_en) begin
          if (r_space + 1'b1 == w_space_len) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_space_nxt = r_space + 1'b1;
          end
        end
      end
      ST_IDLE, ST_DONE, ST_HALT: ;
      default: w_state_nxt = ST_IDLE;
    endcase

    // row_start is judged after any same-cycle byte, so a byte that completes
    // the row turns a would-be underrun into a normal row change.
    if (row_start && (r_state != ST_HALT) && !w_halt_eos) begin
      if (((r_state == ST_REQ) && !w_row_end) || (r_state == ST_SPACE)) begin
        w_set_underrun = 1'b1;
        w_wbank_nxt    = ~r_wbank;
        w_state_nxt    = ST_HALT;
      end else if (cfg_dma_en) begin
        w_state_nxt     = ST_REQ;
        w_wbank_nxt     = ~r_wbank;
        w_col_nxt       = '0;
        w_fifo_wp_nxt   = '0;
        w_burst_nxt     = '0;
        w_space_nxt     = '0;
        w_attr_pend_nxt = 1'b0;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end

    if (frame_start) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_wbank     <= 1'b0;
      r_col       <= '0;
      r_fifo_wp   <= '0;
      r_burst     <= '0;
      r_space     <= '0;
      r_attr_pend <= 1'b0;
      r_dack_q    <= 1'b0;
      r_underrun  <= 1'b0;
      r_overrun   <= 1'b0;
      r_eos       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wbank     <= w_wbank_nxt;
      r_col       <= w_col_nxt;
      r_fifo_wp   <= w_fifo_wp_nxt;
      r_burst     <= w_burst_nxt;
      r_space     <= w_space_nxt;
      r_attr_pend <= w_attr_pend_nxt;
      r_dack_q    <= dack;
      // A set event in the same cycle as status_clr wins.
      r_underrun  <= w_set_underrun | (r_underrun & ~status_clr);
      r_overrun   <= w_set_overrun  | (r_overrun  & ~status_clr);
      r_eos       <= w_set_eos      | (r_eos      & ~status_clr);
    end
  end

  assign drq         = (r_state == ST_REQ);
  assign row_done    = (r_state == ST_DONE);
  assign st_underrun = r_underrun;
  assign st_overrun  = r_overrun;
  assign st_eos      = r_eos;

  crt_row_ram #(.DEPTH(COLS), .WIDTH(8)) u_row_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_row_we),
    .i_wr_bank (r_wbank),
    .i_wr_addr (r_col[CW-1:0]),
    .i_wr_data (ichar),
    .i_rd_bank (~r_wbank),
    .i_rd_addr (rd_col),
    .o_rd_data (rd_char)
  );

  crt_row_ram #(.DEPTH(FIFO_DEPTH), .WIDTH(7)) u_fifo_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_fifo_we),
    .i_wr_bank (r_wbank),
    .i_wr_addr (r_fifo_wp[FW-1:0]),
    .i_wr_data (ichar[6:0]),
    .i_rd_bank (~r_wbank),
    .i_rd_addr (rd_fidx),
    .o_rd_data (rd_fdata)
  );

endmodule

// File: tb/tb_crt_row_fetch.sv
// -----------------------------------------------------------------------------
// tb_crt_row_fetch
// Self-checking bench for crt_row_fetch. Display-bank reads are queued with
// their expected value and compared when the registered read data appears.
// -----------------------------------------------------------------------------
module tb_crt_row_fetch;

  localparam int COLS       = 80;
  localparam int FIFO_DEPTH = 16;
  localparam int CW         = $clog2(COLS);
  localparam int FW         = $clog2(FIFO_DEPTH);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          char_en;
  logic          frame_start;
  logic          row_start;
  logic [CW-1:0] cfg_cols;
  logic          cfg_fillattr;
  logic [1:0]    cfg_burst_cnt;
  logic [2:0]    cfg_burst_space;
  logic          cfg_dma_en;
  logic          drq;
  logic          dack;
  logic [7:0]    ichar;
  logic [CW-1:0] rd_col;
  logic [7:0]    rd_char;
  logic [FW-1:0] rd_fidx;
  logic [6:0]    rd_fdata;
  logic          row_done;
  logic          st_underrun;
  logic          st_overrun;
  logic          st_eos;
  logic          status_clr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         fifo;
    int         addr;
    logic [7:0] exp;
  } rd_req_t;

  rd_req_t req_q[$];   // reads waiting to be issued
  rd_req_t sb_q[$];    // reads issued, awaiting registered data

  crt_row_fetch #(.COLS(COLS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .char_en         (char_en),
    .frame_start     (frame_start),
    .row_start       (row_start),
    .cfg_cols        (cfg_cols),
    .cfg_fillattr    (cfg_fillattr),
    .cfg_burst_cnt   (cfg_burst_cnt),
    .cfg_burst_space (cfg_burst_space),
    .cfg_dma_en      (cfg_dma_en),
    .drq             (drq),
    .dack            (dack),
    .ichar           (ichar),
    .rd_col          (rd_col),
    .rd_char         (rd_char),
    .rd_fidx         (rd_fidx),
    .rd_fdata        (rd_fdata),
    .row_done        (row_done),
    .st_underrun     (st_underrun),
    .st_overrun      (st_overrun),
    .st_eos          (st_eos),
    .status_clr      (status_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_row_start();
    row_start = 1'b1;
    tick();
    row_start = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_status_clr();
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
  endtask

  // One DMA byte: waits (bounded) for drq, then one cycle with dack high
  // and one with dack low so the next transfer produces a fresh edge.
  task automatic xfer(input logic [7:0] b);
    int n = 0;
    while (!drq && n < 100) begin
      tick();
      n++;
    end
    if (!drq) check("drq_wait", {31'd0, drq}, 32'd1);
    ichar = b;
    dack  = 1'b1;
    tick();
    dack  = 1'b0;
    tick();
  endtask

  function automatic void want_row(input int a, input logic [7:0] e);
    rd_req_t r;
    r.fifo = 1'b0;
    r.addr = a;
    r.exp  = e;
    req_q.push_back(r);
  endfunction

  function automatic void want_fifo(input int a, input logic [7:0] e);
    rd_req_t r;
    r.fifo = 1'b1;
    r.addr = a;
    r.exp  = e;
    req_q.push_back(r);
  endfunction

  task automatic run_reads();
    rd_req_t r;
    rd_req_t e;
    while (req_q.size() > 0) begin
      r = req_q.pop_front();
      if (r.fifo) rd_fidx = FW'(r.addr);
      else        rd_col  = CW'(r.addr);
      sb_q.push_back(r);
      tick();
      e = sb_q.pop_front();
      if (e.fifo) check($sformatf("rd_fdata[%0d]", e.addr), {25'd0, rd_fdata}, {24'd0, e.exp});
      else        check($sformatf("rd_char[%0d]", e.addr),  {24'd0, rd_char},  {24'd0, e.exp});
    end
  endtask

  initial begin
    int cnt;
    int k;

    reset_n         = 1'b0;
    char_en         = 1'b0;
    frame_start     = 1'b0;
    row_start       = 1'b0;
    cfg_cols        = CW'(79);
    cfg_fillattr    = 1'b1;
    cfg_burst_cnt   = 2'd0;
    cfg_burst_space = 3'd0;
    cfg_dma_en      = 1'b1;
    dack            = 1'b0;
    ichar           = 8'h00;
    rd_col          = '0;
    rd_fidx         = '0;
    status_clr      = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_drq",      {31'd0, drq},         32'd0);
    check("rst_row_done", {31'd0, row_done},    32'd0);
    check("rst_underrun", {31'd0, st_underrun}, 32'd0);
    check("rst_overrun",  {31'd0, st_overrun},  32'd0);
    check("rst_eos",      {31'd0, st_eos},      32'd0);
    check("rst_rd_char",  {24'd0, rd_char},     32'd0);
    check("rst_rd_fdata", {25'd0, rd_fdata},    32'd0);
    reset_n = 1'b1;
    tick();

    // Full 80-column row, single-byte bursts, no spacing
    pulse_frame_start();
    pulse_row_start();
    check("drq_rise", {31'd0, drq}, 32'd1);
    for (int i = 0; i < 80; i++) begin
      xfer(8'h41);
      if (i == 78) check("drq_before_last", {31'd0, drq}, 32'd1);
    end
    check("drq_fall_row", {31'd0, drq},      32'd0);
    check("row_done",     {31'd0, row_done}, 32'd1);
    pulse_row_start();
    check("row_done_clr", {31'd0, row_done}, 32'd0);
    for (int c = 0; c < 80; c++) want_row(c, 8'h41);
    run_reads();

    // Transparent field attribute
    cfg_fillattr = 1'b0;
    cfg_cols     = CW'(1);
    xfer(8'h80);
    xfer(8'h15);
    xfer(8'h41);
    check("attr_row_done", {31'd0, row_done}, 32'd1);
    pulse_row_start();
    want_row(0, 8'h80);
    want_row(1, 8'h41);
    want_fifo(0, 8'h15);
    run_reads();

    // FIFO overrun: 17 attributes into 16 entries
    cfg_cols = CW'(16);
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check("no_overrun_16", {31'd0, st_overrun}, 32'd0);
      xfer(8'(8'h80 + i));
      xfer(8'(8'h20 + i));
    end
    check("overrun_set",      {31'd0, st_overrun}, 32'd1);
    check("overrun_row_done", {31'd0, row_done},   32'd1);
    pulse_row_start();
    want_fifo(15, 8'h2F);
    want_fifo(0,  8'h20);
    want_row(16,  8'h90);
    run_reads();
    pulse_status_clr();
    check("overrun_clr", {31'd0, st_overrun}, 32'd0);

    // Burst of 4 with 7 char clocks of spacing
    cfg_fillattr    = 1'b1;
    cfg_cols        = CW'(79);
    cfg_burst_cnt   = 2'd2;
    cfg_burst_space = 3'd1;
    for (int i = 0; i < 4; i++) begin
      xfer(8'(8'h30 + i));
      check($sformatf("burst_drq_%0d", i), {31'd0, drq}, (i < 3) ? 32'd1 : 32'd0);
    end
    cnt = 0;
    k   = 0;
    while (!drq && k < 200) begin
      char_en = (k % 3 == 0);
      tick();
      if (char_en) cnt++;
      char_en = 1'b0;
      k++;
    end
    check("space_char_en", cnt,          32'd7);
    check("space_drq_back", {31'd0, drq}, 32'd1);

    // End-of-screen stop code at column 5
    cfg_burst_cnt   = 2'd0;
    cfg_burst_space = 3'd0;
    xfer(8'h42);
    xfer(8'hF3);
    check("eos_set",      {31'd0, st_eos},   32'd1);
    check("eos_drq",      {31'd0, drq},      32'd0);
    check("eos_row_done", {31'd0, row_done}, 32'd0);
    pulse_row_start();
    repeat (3) tick();
    check("eos_ignore_rs", {31'd0, drq}, 32'd0);
    want_row(0, 8'h80);
    run_reads();
    pulse_frame_start();
    check("eos_sticky", {31'd0, st_eos}, 32'd1);
    pulse_row_start();
    check("eos_rearm", {31'd0, drq}, 32'd1);
    want_row(0, 8'h30);
    want_row(4, 8'h42);
    want_row(5, 8'hF3);
    run_reads();

    // Underrun after 40 of 80 transfers; set wins over a same-cycle clear
    for (int i = 0; i < 40; i++) xfer(8'h55);
    row_start  = 1'b1;
    status_clr = 1'b1;
    tick();
    row_start  = 1'b0;
    status_clr = 1'b0;
    check("underrun_set", {31'd0, st_underrun}, 32'd1);
    check("underrun_drq", {31'd0, drq},         32'd0);
    pulse_row_start();
    repeat (2) tick();
    check("underrun_halt", {31'd0, drq}, 32'd0);
    want_row(39, 8'h55);
    want_row(0,  8'h55);
    run_reads();
    pulse_status_clr();
    check("underrun_clr", {31'd0, st_underrun}, 32'd0);
    pulse_frame_start();
    pulse_row_start();
    check("underrun_rearm", {31'd0, drq}, 32'd1);

    // Reset mid-fetch
    xfer(8'h11);
    reset_n = 1'b0;
    tick();
    check("midrst_drq",      {31'd0, drq},      32'd0);
    check("midrst_row_done", {31'd0, row_done}, 32'd0);
    check("midrst_rd_char",  {24'd0, rd_char},  32'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
